max7219_rx: RTL and testbench

MAX7219_RX -- requirements
Module: max7219_rx

---
 rtl/max7219_rx_if.sv | 30 +++
 rtl/max7219_rx.sv | 206 ++++++++++++++++++++
 tb/tb_max7219_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/max7219_rx_if.sv
// max7219_rx_if -- latched-word output bus of the MAX7219 receiver.
//
// Signals:
//   word_valid  one-cycle pulse, a full word was latched this cycle
//   word_addr   address byte of the last latched word ({4'h0, addr nibble})
//   word_data   data byte of the last latched word
//   frame_err   one-cycle pulse, cs rose before 16 bits were shifted in
//
// master: the receiver (drives the bus); slave: the consumer.

interface max7219_rx_if;
    logic       word_valid;
    logic [7:0] word_addr;
    logic [7:0] word_data;
    logic       frame_err;

    modport master (
        output word_valid,
        output word_addr,
        output word_data,
        output frame_err
    );

    modport slave (
        input word_valid,
        input word_addr,
        input word_data,
        input frame_err
    );
endinterface

// File: rtl/max7219_rx.sv
// max7219_rx -- register-compatible receiver for the MAX7219 serial protocol.
//
// The cs/sck/din pins are asynchronous. They are synchronized into clk,
// edges are detected, 16-bit words are shifted in MSB first and latched
// into the digit/control registers on the cs rising edge.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth for cs/sck/din (2..3)
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cs, sck, din        serial pins (LOAD, CLK, DIN)
//   rd_addr / rd_data   combinational read of digit register 0..7
//   decode_mode, intensity, scan_limit, shutdown_n, display_test
//                       current control register values
//   dout                daisy-chain output
//   wbus                latched-word bus (word_valid/addr/data, frame_err)
//
// Build option:
//   MAX7219_RX_DOUT_EN  when defined, dout carries the bit pushed out of
//                       the shift register (delayed to sck falling edge);
//                       otherwise dout is tied low.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for cs to fall
// SHIFT  | frame active, sampling din on sck rising edges
// LATCH  | one cycle after cs rose; word was committed on entry

module max7219_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cs,
    input  logic                sck,
    input  logic                din,
    input  logic [2:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic [7:0]          decode_mode,
    output logic [3:0]          intensity,
    output logic [2:0]          scan_limit,
    output logic                shutdown_n,
    output logic                display_test,
    output logic                dout,
    max7219_rx_if.master        wbus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic                   cs_dly_q;
    logic                   sck_dly_q;
    // Fills with ones after reset; edges are trusted only once the
    // synchronizer and delay flop hold real pin samples. Without this the
    // reset value of cs (high) would fake a falling edge when reset is
    // released in the middle of a frame.
    logic [SYNC_STAGES:0]   flush_q;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] shift_q;
    logic [7:0]  digit_q [8];
    logic [7:0]  decode_mode_q;
    logic [3:0]  intensity_q;
    logic [2:0]  scan_limit_q;
    logic        shutdown_n_q;
    logic        display_test_q;
    logic        word_valid_q;
    logic [7:0]  word_addr_q;
    logic [7:0]  word_data_q;
    logic        frame_err_q;

    logic cs_s, sck_s, din_s;
    logic edges_ok;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign din_s    = din_sync_q[SYNC_STAGES-1];
    assign edges_ok = flush_q[SYNC_STAGES];
    assign cs_fall  = edges_ok &  cs_dly_q  & ~cs_s;
    assign cs_rise  = edges_ok & ~cs_dly_q  &  cs_s;
    assign sck_rise = edges_ok & ~sck_dly_q &  sck_s;
    assign sck_fall = edges_ok &  sck_dly_q & ~sck_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '0;
            din_sync_q <= '0;
            cs_dly_q   <= 1'b1;
            sck_dly_q  <= 1'b0;
            flush_q    <= '0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
            cs_dly_q   <= cs_s;
            sck_dly_q  <= sck_s;
            flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            shift_q        <= '0;
            for (int i = 0; i < 8; i++) digit_q[i] <= '0;
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
            word_valid_q   <= 1'b0;
            word_addr_q    <= '0;
            word_data_q    <= '0;
            frame_err_q    <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= '0;
                    end
                end
                ST_SHIFT: begin
                    // The commit happens on the transition into LATCH so
                    // that word_valid and the register update are visible
                    // during the LATCH cycle, one cycle after cs_rise.
                    if (cs_rise) begin
                        state_q <= ST_LATCH;
                        if (cnt_q >= 5'd16) begin
                            word_valid_q <= 1'b1;
                            word_addr_q  <= {4'h0, shift_q[11:8]};
                            word_data_q  <= shift_q[7:0];
                            case (shift_q[11:8])
                                4'h1, 4'h2, 4'h3, 4'h4,
                                4'h5, 4'h6, 4'h7, 4'h8:
                                    digit_q[3'(shift_q[11:8] - 4'd1)] <= shift_q[7:0];
                                4'h9: decode_mode_q  <= shift_q[7:0];
                                4'hA: intensity_q    <= shift_q[3:0];
                                4'hB: scan_limit_q   <= shift_q[2:0];
                                4'hC: shutdown_n_q   <= shift_q[0];
                                4'hF: display_test_q <= shift_q[0];
                                default: ;
                            endcase
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        shift_q <= {shift_q[14:0], din_s};
                        if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_LATCH: state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MAX7219_RX_DOUT_EN
    logic hold_q;
    logic dout_q;

    // The bit leaving shift[15] is held on the sck rising edge and
    // presented on the following falling edge, so the next device in the
    // chain sees stable data around its own rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= 1'b0;
            dout_q <= 1'b0;
        end else if (state_q == ST_SHIFT) begin
            if (sck_rise && !cs_rise) hold_q <= shift_q[15];
            if (sck_fall)             dout_q <= hold_q;
        end
    end

    assign dout = dout_q;
`else
    logic unused_dout_bits;
    assign unused_dout_bits = shift_q[15] ^ sck_fall;
    assign dout = 1'b0;
`endif

    assign rd_data         = digit_q[rd_addr];
    assign decode_mode     = decode_mode_q;
    assign intensity       = intensity_q;
    assign scan_limit      = scan_limit_q;
    assign shutdown_n      = shutdown_n_q;
    assign display_test    = display_test_q;
    assign wbus.word_valid = word_valid_q;
    assign wbus.word_addr  = word_addr_q;
    assign wbus.word_data  = word_data_q;
    assign wbus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_max7219_rx.sv
module tb_max7219_rx;
    localparam int SYNC = 2;
    localparam int HALF = 5;   // sck phase length in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       cs, sck, din;
    logic [2:0] rd_addr;
    logic [7:0] rd_data, decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n, display_test, dout;

    max7219_rx_if wbus ();

    max7219_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cs           (cs),
        .sck          (sck),
        .din          (din),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .dout         (dout),
        .wbus         (wbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       err;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every pulse on the word bus must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!rst && (wbus.word_valid || wbus.frame_err)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", {wbus.word_valid, wbus.frame_err}, 2'b00);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_kind", {wbus.word_valid, wbus.frame_err}, mon_e.err ? 2'b01 : 2'b10);
                if (!mon_e.err) begin
                    chk("sb_addr", wbus.word_addr, mon_e.addr);
                    chk("sb_data", wbus.word_data, mon_e.data);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits MSB first; returns dout sampled after each falling edge.
    task automatic shift_bits(input logic [31:0] bits, input int n, output logic [31:0] dbits);
        dbits = '0;
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
            wait_clk(HALF);
            dbits = {dbits[30:0], dout};
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, output logic [31:0] dbits);
        exp_t e;
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(bits, n, dbits);
        e.err  = (n < 16);
        e.addr = {4'h0, bits[11:8]};
        e.data = bits[7:0];
        sb_q.push_back(e);
        cs = 1'b1;
        // Rise is detected after SYNC edges; pulse follows one edge later.
        repeat (SYNC) @(posedge clk);
        @(negedge clk);
        chk("lat_early", {wbus.word_valid, wbus.frame_err}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk("lat_pulse", {wbus.word_valid, wbus.frame_err}, (n < 16) ? 2'b01 : 2'b10);
        wait_clk(8);
    endtask

    logic [31:0] db;

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; din = 1'b0; rd_addr = '0;
        wait_clk(3);
        chk("rst_ctrl", {decode_mode, intensity, scan_limit, shutdown_n, display_test}, '0);
        chk("rst_word", {wbus.word_valid, wbus.frame_err, wbus.word_addr, wbus.word_data}, '0);
        chk("rst_dout", dout, 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1 chk("rst_digit", rd_data, 8'h00);
        end
        rst = 1'b0;
        wait_clk(8);

        send_frame(32'h0C01, 16, db);
        chk("shutdown_on", shutdown_n, 1'b1);

        send_frame(32'h0355, 16, db);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1 chk("digit_read", rd_data, (a == 2) ? 8'h55 : 8'h00);
        end

        send_frame(32'hA07, 12, db);
        chk("short_int", intensity, 4'h0);
        chk("short_addr", wbus.word_addr, 8'h03);

        send_frame(32'hF0A07, 20, db);
        chk("long_int", intensity, 4'h7);
        chk("long_addr", wbus.word_addr, 8'h0A);

        send_frame(32'h0801, 16, db);
        rd_addr = 3'd7;
        #1 chk("digit7", rd_data, 8'h01);

        send_frame(32'h09A5, 16, db);
        chk("decode", decode_mode, 8'hA5);
        send_frame(32'h0D33, 16, db);
        send_frame(32'h0E44, 16, db);
        send_frame(32'h0066, 16, db);
        chk("noop_decode", decode_mode, 8'hA5);
        chk("noop_int", intensity, 4'h7);
        rd_addr = 3'd2;
        #1 chk("noop_digit2", rd_data, 8'h55);

        send_frame(32'h0F01, 16, db);
        chk("dtest_on", display_test, 1'b1);
        send_frame(32'h0F00, 16, db);
        chk("dtest_off", display_test, 1'b0);

        // Frame interrupted by reset must vanish without a trace.
        wait_clk(2);
        cs = 1'b0;
        wait_clk(HALF);
        shift_bits(32'h0B, 8, db);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(HALF);
        cs = 1'b1;
        wait_clk(20);
        chk("rst_scan", scan_limit, 3'h0);
        chk("rst_shdn", shutdown_n, 1'b0);
        chk("rst_int", intensity, 4'h0);

        send_frame(32'h0F010B05, 32, db);
        chk("chain_scan", scan_limit, 3'h5);
        chk("chain_dtest", display_test, 1'b0);
`ifdef MAX7219_RX_DOUT_EN
        chk("dout_seq", db[15:0], 16'h0F01);
`else
        chk("dout_tied", db, 32'h0);
`endif

        wait_clk(4);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
